periph_interconnect: RTL and testbench

PERIPH_INTERCONNECT -- requirements
Module: periph_interconnect

---
 rtl/periph_pkg.sv | 30 +++
 rtl/periph_addr_decode.sv | 31 +++
 rtl/periph_interconnect.sv | 179 +++++++++++++++++
 tb/tb_periph_interconnect.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_pkg.sv
// periph_pkg
// Shared definitions for the peripheral interconnect:
//   - periph_state_e : FSM state encoding (IDLE / ACCESS / ERROR)
//   - SLV_BASE/SLV_MASK : per-slave address window; slave k matches when
//     (addr & SLV_MASK[k]) == SLV_BASE[k]. Eight entries are provided so any
//     NSLV in 1..8 can be built; only the first NSLV are decoded.
//   - TIMEOUT_DEF : default ACCESS-cycle budget before a bus error.
package periph_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERROR  = 2'd2
  } periph_state_e;

  localparam int MAX_SLV     = 8;
  localparam int TIMEOUT_DEF = 16;

  // DM, UART, GPIO, TIMER, then four spare 1 KiB windows.
  localparam logic [31:0] SLV_BASE [MAX_SLV] = '{
    32'h0000_0000, 32'h0000_0400, 32'h0000_0800, 32'h0000_0C00,
    32'h0000_1000, 32'h0000_1400, 32'h0000_1800, 32'h0000_1C00
  };

  localparam logic [31:0] SLV_MASK [MAX_SLV] = '{
    32'hFFFF_FC00, 32'hFFFF_FC00, 32'hFFFF_FC00, 32'hFFFF_FC00,
    32'hFFFF_FC00, 32'hFFFF_FC00, 32'hFFFF_FC00, 32'hFFFF_FC00
  };

endpackage

// File: rtl/periph_addr_decode.sv
// periph_addr_decode
// Combinational address decoder.
//   addr_i : core byte address
//   hit_o  : some slave window matches addr_i
//   sel_o  : index of the matching slave (lowest index wins on overlap)
module periph_addr_decode
  import periph_pkg::*;
#(
  parameter int AW   = 32,
  parameter int NSLV = 4,
  parameter int SW   = 2
) (
  input  logic [AW-1:0] addr_i,
  output logic          hit_o,
  output logic [SW-1:0] sel_o
);

  // Scan from the highest index down so the last assignment, i.e. the
  // lowest matching index, is the one that sticks.
  always_comb begin
    hit_o = 1'b0;
    sel_o = '0;
    for (int k = NSLV - 1; k >= 0; k--) begin
      if ((addr_i & AW'(SLV_MASK[k])) == AW'(SLV_BASE[k])) begin
        hit_o = 1'b1;
        sel_o = SW'(k);
      end
    end
  end

endmodule

// File: rtl/periph_interconnect.sv
// periph_interconnect
// Single-master to NSLV-slave peripheral interconnect with timeout.
//
// Core side handshake: the core raises req_i with we_i/addr_i/data_store_i/
// mask_i while busy_o=0; the request is taken on that clock edge. The core
// must then hold off until it sees the one-cycle ack_o pulse (err_o
// qualifies it). Requests seen while busy_o=1 are ignored.
// Slave side: cs_o is one-hot for the selected slave during ACCESS; the slave
// finishes by raising its slv_ready_i bit, sampled on the clock edge together
// with its slv_data_i lane.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req_i, we_i, addr_i,
//   data_store_i, mask_i    core request
//   data_load_o, ack_o,
//   err_o, busy_o           core response / status
//   cs_o, slv_we_o,
//   slv_addr_o, slv_data_o,
//   slv_mask_o              slave request (word offset within window)
//   slv_data_i, slv_ready_i slave response, slave k at [k*DW +: DW]
module periph_interconnect
  import periph_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int NSLV    = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [DW-1:0]      data_store_i,
  input  logic [DW/8-1:0]    mask_i,
  output logic [DW-1:0]      data_load_o,
  output logic               ack_o,
  output logic               err_o,
  output logic               busy_o,
  output logic [NSLV-1:0]    cs_o,
  output logic               slv_we_o,
  output logic [AW-3:0]      slv_addr_o,
  output logic [DW-1:0]      slv_data_o,
  output logic [DW/8-1:0]    slv_mask_o,
  input  logic [NSLV*DW-1:0] slv_data_i,
  input  logic [NSLV-1:0]    slv_ready_i
);

  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

  periph_state_e     state_q, state_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW/8-1:0]   mask_q, mask_d;
  logic              we_q, we_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic [DW-1:0]     rdata_q, rdata_d;

  logic              dec_hit;
  logic [SW-1:0]     dec_sel;

  logic              sel_ready;
  logic [DW-1:0]     sel_data;
  logic [AW-1:0]     sel_mask;

  periph_addr_decode #(
    .AW   (AW),
    .NSLV (NSLV),
    .SW   (SW)
  ) u_decode (
    .addr_i (addr_i),
    .hit_o  (dec_hit),
    .sel_o  (dec_sel)
  );

  // Per-slave muxing keyed by the latched select.
  always_comb begin
    sel_ready = 1'b0;
    sel_data  = '0;
    sel_mask  = '0;
    cs_o      = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (sel_q == SW'(k)) begin
        sel_ready = slv_ready_i[k];
        sel_data  = slv_data_i[k*DW +: DW];
        sel_mask  = AW'(SLV_MASK[k]);
        cs_o[k]   = (state_q == ST_ACCESS);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          if (dec_hit) begin
            sel_d   = dec_sel;
            addr_d  = addr_i;
            wdata_d = data_store_i;
            mask_d  = mask_i;
            we_d    = we_i;
            cnt_d   = '0;
            state_d = ST_ACCESS;
          end else begin
            rdata_d = '0;
            state_d = ST_ERROR;
          end
        end
      end
      ST_ACCESS: begin
        // Ready is checked first so it wins over an expiring counter.
        if (sel_ready) begin
          rdata_d = sel_data;
          ack_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          rdata_d = '0;
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_ERROR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  // The ERROR state is itself the error-acknowledge cycle; rdata_q was
  // cleared on the way in, so data_load_o reads 0 there.
  assign ack_o       = ack_q | (state_q == ST_ERROR);
  assign err_o       = (state_q == ST_ERROR);
  assign busy_o      = (state_q != ST_IDLE);
  assign data_load_o = rdata_q;
  assign slv_we_o    = we_q;
  assign slv_data_o  = wdata_q;
  assign slv_mask_o  = mask_q;
  assign slv_addr_o  = (AW-2)'((addr_q & ~sel_mask) >> 2);

endmodule

// File: tb/tb_periph_interconnect.sv
module tb_periph_interconnect;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int NSLV = 4;

  logic               clk;
  logic               rst_n;
  logic               req_i;
  logic               we_i;
  logic [AW-1:0]      addr_i;
  logic [DW-1:0]      data_store_i;
  logic [DW/8-1:0]    mask_i;
  logic [DW-1:0]      data_load_o;
  logic               ack_o;
  logic               err_o;
  logic               busy_o;
  logic [NSLV-1:0]    cs_o;
  logic               slv_we_o;
  logic [AW-3:0]      slv_addr_o;
  logic [DW-1:0]      slv_data_o;
  logic [DW/8-1:0]    slv_mask_o;
  logic [NSLV*DW-1:0] slv_data_i;
  logic [NSLV-1:0]    slv_ready_i;

  int checks;
  int failures;

  localparam logic [DW-1:0] DM_DATA    = 32'h1234_5678;
  localparam logic [DW-1:0] UART_DATA  = 32'h0000_00A5;
  localparam logic [DW-1:0] GPIO_DATA  = 32'hC0FF_EE00;
  localparam logic [DW-1:0] TIMER_DATA = 32'h7777_0003;

  periph_interconnect #(
    .DW(DW), .AW(AW), .NSLV(NSLV), .TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .data_store_i (data_store_i),
    .mask_i       (mask_i),
    .data_load_o  (data_load_o),
    .ack_o        (ack_o),
    .err_o        (err_o),
    .busy_o       (busy_o),
    .cs_o         (cs_o),
    .slv_we_o     (slv_we_o),
    .slv_addr_o   (slv_addr_o),
    .slv_data_o   (slv_data_o),
    .slv_mask_o   (slv_mask_o),
    .slv_data_i   (slv_data_i),
    .slv_ready_i  (slv_ready_i)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic [DW/8-1:0] m);
    req_i        = 1'b1;
    we_i         = we;
    addr_i       = addr;
    data_store_i = wd;
    mask_i       = m;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; data_store_i = '0; mask_i = '0;
    slv_ready_i = '0;
    slv_data_i  = {TIMER_DATA, GPIO_DATA, UART_DATA, DM_DATA};
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cs_o, ack_o, err_o, busy_o, slv_we_o} !== 8'b0) begin
      failures++;
      $display("FAIL reset_ctrl cs=%b ack=%b err=%b busy=%b we=%b expected all 0",
               cs_o, ack_o, err_o, busy_o, slv_we_o);
    end
    checks++;
    if (data_load_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got=%h expected=0", data_load_o);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_uart_load();
    start_req(1'b0, 32'h0000_0404, 32'h0, 4'h0);
    tick();  // cycle 1
    req_i = 1'b0;
    checks++;
    if (cs_o !== 4'b0010 || busy_o !== 1'b1 || ack_o !== 1'b0) begin
      failures++;
      $display("FAIL uart_c1 cs=%b busy=%b ack=%b expected cs=0010 busy=1 ack=0",
               cs_o, busy_o, ack_o);
    end
    slv_ready_i = 4'b0010;
    tick();  // cycle 2
    slv_ready_i = '0;
    checks++;
    if (ack_o !== 1'b1 || err_o !== 1'b0 || data_load_o !== UART_DATA ||
        slv_addr_o !== 30'd1) begin
      failures++;
      $display("FAIL uart_c2 ack=%b err=%b data=%h saddr=%h expected ack=1 err=0 data=%h saddr=1",
               ack_o, err_o, data_load_o, slv_addr_o, UART_DATA);
    end
    tick();  // cycle 3
    checks++;
    if (ack_o !== 1'b0 || cs_o !== 4'b0 || data_load_o !== UART_DATA) begin
      failures++;
      $display("FAIL uart_c3 ack=%b cs=%b data=%h expected ack=0 cs=0 data held %h",
               ack_o, cs_o, data_load_o, UART_DATA);
    end
  endtask

  task automatic test_dm_store();
    int acks;
    start_req(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF);
    tick();
    req_i = 1'b0;
    acks = 0;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (cs_o !== 4'b0001 || slv_data_o !== 32'hDEAD_BEEF || slv_mask_o !== 4'hF ||
          slv_we_o !== 1'b1 || slv_addr_o !== 30'd2 || ack_o !== 1'b0) begin
        failures++;
        $display("FAIL dm_access cyc=%0d cs=%b sdata=%h smask=%h swe=%b saddr=%h ack=%b expected 0001/deadbeef/f/1/2/0",
                 i, cs_o, slv_data_o, slv_mask_o, slv_we_o, slv_addr_o, ack_o);
      end
      if (i == 4) slv_ready_i = 4'b0001;
      tick();
    end
    slv_ready_i = '0;
    checks++;
    if (ack_o !== 1'b1 || err_o !== 1'b0 || data_load_o !== DM_DATA || cs_o !== 4'b0) begin
      failures++;
      $display("FAIL dm_ack ack=%b err=%b data=%h cs=%b expected 1/0/%h/0000",
               ack_o, err_o, data_load_o, cs_o, DM_DATA);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack_o === 1'b1) acks++;
    end
    checks++;
    if (acks !== 0) begin
      failures++;
      $display("FAIL dm_single_ack extra_acks=%0d expected 0", acks);
    end
  endtask

  task automatic test_unmapped();
    start_req(1'b0, 32'h0000_2000, 32'h0, 4'h0);
    tick();
    req_i = 1'b0;
    checks++;
    if (ack_o !== 1'b1 || err_o !== 1'b1 || data_load_o !== 32'h0 ||
        cs_o !== 4'b0 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL unmapped_c1 ack=%b err=%b data=%h cs=%b busy=%b expected 1/1/0/0000/1",
               ack_o, err_o, data_load_o, cs_o, busy_o);
    end
    tick();
    checks++;
    if (ack_o !== 1'b0 || err_o !== 1'b0 || cs_o !== 4'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL unmapped_c2 ack=%b err=%b cs=%b busy=%b expected all 0",
               ack_o, err_o, cs_o, busy_o);
    end
  endtask

  // GPIO access; other slaves assert ready throughout and must be ignored.
  // ready_last=1 raises GPIO ready in the final (16th) ACCESS cycle.
  task automatic test_timeout(input logic ready_last);
    int bad;
    start_req(1'b0, 32'h0000_0810, 32'h0, 4'h0);
    tick();
    req_i = 1'b0;
    slv_ready_i = 4'b1011;
    bad = 0;
    for (int i = 1; i <= 16; i++) begin
      if (cs_o !== 4'b0100 || ack_o !== 1'b0 || slv_addr_o !== 30'd4) begin
        bad++;
        $display("FAIL timeout_access last=%b cyc=%0d cs=%b ack=%b saddr=%h expected 0100/0/4",
                 ready_last, i, cs_o, ack_o, slv_addr_o);
      end
      if (i == 16 && ready_last) slv_ready_i = 4'b1111;
      tick();
    end
    checks++;
    if (bad != 0) failures++;
    slv_ready_i = '0;
    checks++;
    if (ready_last) begin
      if (ack_o !== 1'b1 || err_o !== 1'b0 || data_load_o !== GPIO_DATA || cs_o !== 4'b0) begin
        failures++;
        $display("FAIL timeout_ready_wins ack=%b err=%b data=%h cs=%b expected 1/0/%h/0000",
                 ack_o, err_o, data_load_o, cs_o, GPIO_DATA);
      end
    end else begin
      if (ack_o !== 1'b1 || err_o !== 1'b1 || data_load_o !== 32'h0 || cs_o !== 4'b0) begin
        failures++;
        $display("FAIL timeout_err ack=%b err=%b data=%h cs=%b expected 1/1/0/0000",
                 ack_o, err_o, data_load_o, cs_o);
      end
    end
    tick();
    checks++;
    if (ack_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL timeout_after ack=%b busy=%b expected 0/0", ack_o, busy_o);
    end
  endtask

  task automatic test_reset_mid();
    start_req(1'b1, 32'h0000_0C00, 32'h5555_AAAA, 4'h3);
    tick();
    req_i = 1'b0;
    checks++;
    if (cs_o !== 4'b1000) begin
      failures++;
      $display("FAIL rstmid_pre cs=%b expected 1000", cs_o);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (cs_o !== 4'b0 || busy_o !== 1'b0 || ack_o !== 1'b0 || slv_we_o !== 1'b0 ||
        data_load_o !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_async cs=%b busy=%b ack=%b we=%b data=%h expected all 0",
               cs_o, busy_o, ack_o, slv_we_o, data_load_o);
    end
    rst_n = 1'b1;
    start_req(1'b0, 32'h0000_0C08, 32'h0, 4'h0);
    tick();
    req_i = 1'b0;
    checks++;
    if (cs_o !== 4'b1000 || slv_we_o !== 1'b0 || slv_addr_o !== 30'd2) begin
      failures++;
      $display("FAIL rstmid_accept cs=%b we=%b saddr=%h expected 1000/0/2",
               cs_o, slv_we_o, slv_addr_o);
    end
    slv_ready_i = 4'b1000;
    tick();
    slv_ready_i = '0;
    checks++;
    if (ack_o !== 1'b1 || err_o !== 1'b0 || data_load_o !== TIMER_DATA) begin
      failures++;
      $display("FAIL rstmid_done ack=%b err=%b data=%h expected 1/0/%h",
               ack_o, err_o, data_load_o, TIMER_DATA);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int acks;
    int cs_bad;
    acks = 0;
    cs_bad = 0;
    start_req(1'b0, 32'h0000_0C04, 32'h0, 4'h0);
    tick();  // cycle 1
    // Core keeps req up and changes the address while busy.
    addr_i = 32'h0000_0404;
    for (int i = 1; i <= 9; i++) begin
      if (ack_o === 1'b1) acks++;
      if (i <= 3 && (cs_o !== 4'b1000 || slv_addr_o !== 30'd1)) cs_bad++;
      if (i > 3 && cs_o !== 4'b0) cs_bad++;
      if (i == 3) begin
        slv_ready_i = 4'b1000;
        req_i = 1'b0;
      end
      tick();
      slv_ready_i = '0;
    end
    checks++;
    if (acks !== 1) begin
      failures++;
      $display("FAIL b2b_acks got=%0d expected 1", acks);
    end
    checks++;
    if (cs_bad !== 0) begin
      failures++;
      $display("FAIL b2b_cs bad_cycles=%0d expected 0", cs_bad);
    end
    checks++;
    if (data_load_o !== TIMER_DATA) begin
      failures++;
      $display("FAIL b2b_data got=%h expected %h", data_load_o, TIMER_DATA);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_uart_load();
    test_dm_store();
    test_unmapped();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: a stuck run still ends with a summary line.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
